// File: rtl/mem_access_sequencer_if.sv
// Request/strobe bundle between the main control FSM (master) and the
// shared-memory-port sequencer (slave).
interface mem_access_sequencer_if;
  logic       fetch_req;
  logic       data_req;
  logic       data_we;
  logic       exc_req;
  logic [1:0] exc_code;
  logic [2:0] addressControl;
  logic       mem_wr;
  logic       ir_write;
  logic       mdr_write;
  logic       epc_write;
  logic       busy;
  logic       done;

  modport master (
    output fetch_req, data_req, data_we, exc_req, exc_code,
    input  addressControl, mem_wr, ir_write, mdr_write, epc_write, busy, done
  );

  modport slave (
    input  fetch_req, data_req, data_we, exc_req, exc_code,
    output addressControl, mem_wr, ir_write, mdr_write, epc_write, busy, done
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multicycle sequencer for the shared memory port: arbitrates fetch, load/store
// and exception-vector reads and steps each through ACCESS, WAIT and CAPTURE.
module mem_access_sequencer #(
  parameter int unsigned MEM_WAIT = 32'd1
) (
  input logic                   clk,
  input logic                   reset,
  mem_access_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2,
    K_EXC   = 2'd3
  } kind_e;

  localparam logic [2:0] WAIT_INIT = MEM_WAIT[2:0];

  state_e     state_q;
  kind_e      kind_q;
  logic [2:0] cnt_q;
  logic [2:0] addr_q;
  logic       mem_wr_q;
  logic       ir_write_q;
  logic       mdr_write_q;
  logic       epc_write_q;
  logic       busy_q;
  logic       done_q;

  logic       cap_ir_s;
  logic       cap_mdr_s;

  // Reserved code 3 shares the invalid-opcode vector.
  function automatic logic [2:0] exc_sel(input logic [1:0] code);
    logic [2:0] sel;
    case (code)
      2'd1:    sel = 3'b010;
      2'd2:    sel = 3'b011;
      default: sel = 3'b001;
    endcase
    return sel;
  endfunction

  assign cap_ir_s  = (kind_q == K_FETCH);
  assign cap_mdr_s = (kind_q == K_LOAD) || (kind_q == K_EXC);

  // Control FSM; every output is a register loaded on entry to the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= K_FETCH;
      cnt_q       <= 3'd0;
      addr_q      <= 3'b000;
      mem_wr_q    <= 1'b0;
      ir_write_q  <= 1'b0;
      mdr_write_q <= 1'b0;
      epc_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_wr_q    <= 1'b0;
      ir_write_q  <= 1'b0;
      mdr_write_q <= 1'b0;
      epc_write_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.exc_req) begin
            state_q     <= S_ACCESS;
            kind_q      <= K_EXC;
            addr_q      <= exc_sel(bus.exc_code);
            epc_write_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (bus.data_req) begin
            state_q  <= S_ACCESS;
            kind_q   <= bus.data_we ? K_STORE : K_LOAD;
            addr_q   <= 3'b100;
            mem_wr_q <= bus.data_we;
            busy_q   <= 1'b1;
          end else if (bus.fetch_req) begin
            state_q <= S_ACCESS;
            kind_q  <= K_FETCH;
            addr_q  <= 3'b000;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            addr_q  <= 3'b000;
            busy_q  <= 1'b0;
          end
        end
        S_ACCESS: begin
          cnt_q <= WAIT_INIT;
          if (WAIT_INIT != 3'd0) begin
            state_q <= S_WAIT;
          end else begin
            state_q     <= S_CAPTURE;
            ir_write_q  <= cap_ir_s;
            mdr_write_q <= cap_mdr_s;
            done_q      <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q     <= S_CAPTURE;
            ir_write_q  <= cap_ir_s;
            mdr_write_q <= cap_mdr_s;
            done_q      <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_CAPTURE: begin
          state_q <= S_IDLE;
          addr_q  <= 3'b000;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          addr_q  <= 3'b000;
          busy_q  <= 1'b0;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.addressControl = addr_q;
  assign bus.mem_wr         = mem_wr_q;
  assign bus.ir_write       = ir_write_q;
  assign bus.mdr_write      = mdr_write_q;
  assign bus.epc_write      = epc_write_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Three sequencers (MEM_WAIT = 1, 3, 0) share one request stream; each is checked every
// cycle against a transaction-level model, plus directed latency/order checks.
module tb_mem_access_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_r;
  logic       fetch_r, data_r, we_r, exc_r;
  logic [1:0] code_r;

  logic [2:0] ac_o   [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic       ir_o   [3];
  logic       mdr_o  [3];
  logic       mwr_o  [3];
  logic       epc_o  [3];

  function automatic int wcfg(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_sequencer_if bus ();
    assign bus.fetch_req = fetch_r;
    assign bus.data_req  = data_r;
    assign bus.data_we   = we_r;
    assign bus.exc_req   = exc_r;
    assign bus.exc_code  = code_r;
    assign ac_o[g]   = bus.addressControl;
    assign busy_o[g] = bus.busy;
    assign done_o[g] = bus.done;
    assign ir_o[g]   = bus.ir_write;
    assign mdr_o[g]  = bus.mdr_write;
    assign mwr_o[g]  = bus.mem_wr;
    assign epc_o[g]  = bus.epc_write;
    mem_access_sequencer #(.MEM_WAIT(wcfg(g))) dut (
      .clk   (clk),
      .reset (rst_r[g]),
      .bus   (bus)
    );
  end

  int total = 0;
  int bad   = 0;

  // Model: position within the current access (0 = idle, 1 = address phase, 2+W = done).
  int         pos  [3];
  int         kind [3];   // 0 fetch, 1 load, 2 store, 3 exc
  logic [2:0] msel [3];

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    logic [2:0] rv;
    logic f, d, w, e;
    logic [1:0] c;
    rv = rst_r; f = fetch_r; d = data_r; w = we_r; e = exc_r; c = code_r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      int len;
      len = 2 + wcfg(i);
      if (rv[i]) pos[i] = 0;
      else if (pos[i] == 0) begin
        if (e) begin
          pos[i] = 1; kind[i] = 3;
          msel[i] = (c == 2'd3) ? 3'd1 : 3'(c) + 3'd1;
        end else if (d) begin
          pos[i] = 1; kind[i] = w ? 2 : 1; msel[i] = 3'd4;
        end else if (f) begin
          pos[i] = 1; kind[i] = 0; msel[i] = 3'd0;
        end
      end else if (pos[i] == len) pos[i] = 0;
      else pos[i] = pos[i] + 1;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      logic act, dn;
      act = (pos[i] != 0);
      dn  = act && (pos[i] == 2 + wcfg(i));
      chk("addr", i, 8'(ac_o[i]), act ? 8'(msel[i]) : 8'd0);
      chk("busy", i, 8'(busy_o[i]), 8'(act));
      chk("done", i, 8'(done_o[i]), 8'(dn));
      chk("mem_wr", i, 8'(mwr_o[i]), 8'(act && pos[i] == 1 && kind[i] == 2));
      chk("epc_write", i, 8'(epc_o[i]), 8'(act && pos[i] == 1 && kind[i] == 3));
      chk("ir_write", i, 8'(ir_o[i]), 8'(dn && kind[i] == 0));
      chk("mdr_write", i, 8'(mdr_o[i]), 8'(dn && (kind[i] == 1 || kind[i] == 3)));
    end
  endtask

  task automatic drain();
    int n;
    fetch_r = 1'b0; data_r = 1'b0; exc_r = 1'b0;
    n = 0;
    while ((busy_o[0] || busy_o[1] || busy_o[2]) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("drain_timeout", 0, 8'd0, 8'd1);
  endtask

  int r_lat, r_addr, r_mwr_cnt, r_mwr_at, r_epc_cnt, r_ir, r_mdr;

  // One access observed on DUT idx; requests dropped in the cycle its done is seen.
  task automatic run_one(input int idx, input logic f, input logic d, input logic w,
                         input logic e, input logic [1:0] c);
    drain();
    fetch_r = f; data_r = d; we_r = w; exc_r = e; code_r = c;
    r_lat = 0; r_addr = -1; r_mwr_cnt = 0; r_mwr_at = 0; r_epc_cnt = 0; r_ir = 0; r_mdr = 0;
    while (r_lat < 30) begin
      step();
      r_lat++;
      if (r_lat == 1) r_addr = int'(ac_o[idx]);
      if (mwr_o[idx]) begin r_mwr_cnt++; r_mwr_at = r_lat; end
      if (epc_o[idx]) r_epc_cnt++;
      if (done_o[idx]) begin
        r_ir = int'(ir_o[idx]); r_mdr = int'(mdr_o[idx]);
        fetch_r = 1'b0; data_r = 1'b0; exc_r = 1'b0;
        break;
      end
    end
    if (r_lat >= 30) chk("access_timeout", idx, 8'd0, 8'd1);
  endtask

  initial begin
    int       served, gap, cyc;
    logic     prev_busy;
    int       acc_addr[$];
    int       gaps[$];
    int       first_epc;
    logic [1:0] codes[3];
    logic [2:0] exp_sel[3];

    for (int i = 0; i < 3; i++) begin pos[i] = 0; kind[i] = 0; msel[i] = 3'd0; end
    fetch_r = 1'b0; data_r = 1'b0; we_r = 1'b0; exc_r = 1'b0; code_r = 2'd0;

    // Reset for two cycles, then idle with no requests.
    rst_r = 3'b111;
    step(); step();
    rst_r = 3'b000;
    for (int k = 0; k < 6; k++) step();
    chk("idle_busy", 0, 8'(busy_o[0]), 8'd0);
    chk("idle_addr", 0, 8'(ac_o[0]), 8'd0);

    // Fetch with MEM_WAIT=1.
    run_one(0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("fetch_lat", 0, 8'(r_lat), 8'd3);
    chk("fetch_addr", 0, 8'(r_addr), 8'd0);
    chk("fetch_ir", 0, 8'(r_ir), 8'd1);

    // Store then load.
    run_one(0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("store_lat", 0, 8'(r_lat), 8'd3);
    chk("store_addr", 0, 8'(r_addr), 8'd4);
    chk("store_wr_cnt", 0, 8'(r_mwr_cnt), 8'd1);
    chk("store_wr_at", 0, 8'(r_mwr_at), 8'd1);
    chk("store_nocap", 0, 8'(r_ir + r_mdr), 8'd0);
    run_one(0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("load_lat", 0, 8'(r_lat), 8'd3);
    chk("load_wr_cnt", 0, 8'(r_mwr_cnt), 8'd0);
    chk("load_mdr", 0, 8'(r_mdr), 8'd1);

    // Priority: exc(2) > data > fetch, each dropped at its own done.
    drain();
    exc_r = 1'b1; code_r = 2'd2; data_r = 1'b1; we_r = 1'b0; fetch_r = 1'b1;
    served = 0; gap = 0; cyc = 0; prev_busy = 1'b0; first_epc = 0;
    while (served < 3 && cyc < 40) begin
      step();
      cyc++;
      if (busy_o[0] && !prev_busy) begin
        acc_addr.push_back(int'(ac_o[0]));
        if (served == 0) first_epc = int'(epc_o[0]);
        if (served > 0) gaps.push_back(gap);
        gap = 0;
      end else if (!busy_o[0]) gap++;
      if (done_o[0]) begin
        served++;
        if (served == 1) exc_r = 1'b0;
        else if (served == 2) data_r = 1'b0;
        else fetch_r = 1'b0;
      end
      prev_busy = busy_o[0];
    end
    chk("prio_served", 0, 8'(served), 8'd3);
    chk("prio_n", 0, 8'(acc_addr.size()), 8'd3);
    if (acc_addr.size() == 3) begin
      chk("prio_first", 0, 8'(acc_addr[0]), 8'd3);
      chk("prio_second", 0, 8'(acc_addr[1]), 8'd4);
      chk("prio_third", 0, 8'(acc_addr[2]), 8'd0);
    end
    chk("prio_epc", 0, 8'(first_epc), 8'd1);
    chk("prio_gaps", 0, 8'(gaps.size()), 8'd2);
    foreach (gaps[k]) chk("prio_gap", 0, 8'(gaps[k]), 8'd1);

    // Exception codes 0, 1, 3.
    codes = '{2'd0, 2'd1, 2'd3};
    exp_sel = '{3'd1, 3'd2, 3'd1};
    for (int k = 0; k < 3; k++) begin
      run_one(0, 1'b0, 1'b0, 1'b0, 1'b1, codes[k]);
      chk("exc_addr", 0, 8'(r_addr), 8'(exp_sel[k]));
      chk("exc_mdr", 0, 8'(r_mdr), 8'd1);
      chk("exc_epc_cnt", 0, 8'(r_epc_cnt), 8'd1);
    end

    // MEM_WAIT=3: reset during the second WAIT cycle aborts without done.
    drain();
    fetch_r = 1'b1;
    step();
    fetch_r = 1'b0;
    chk("mid_access", 1, 8'(busy_o[1]), 8'd1);
    step(); step();
    rst_r[1] = 1'b1;
    step();
    rst_r[1] = 1'b0;
    chk("mid_busy", 1, 8'(busy_o[1]), 8'd0);
    chk("mid_addr", 1, 8'(ac_o[1]), 8'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_nodone", 1, 8'(done_o[1]), 8'd0);
    end

    // MEM_WAIT=0 fetch latency; MEM_WAIT=3 latency.
    run_one(2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("w0_lat", 2, 8'(r_lat), 8'd2);
    chk("w0_ir", 2, 8'(r_ir), 8'd1);
    run_one(1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("w3_lat", 1, 8'(r_lat), 8'd5);

    // Random requests and occasional resets against the model.
    for (int k = 0; k < 600; k++) begin
      fetch_r = ($urandom_range(0, 2) == 0);
      data_r  = ($urandom_range(0, 3) == 0);
      we_r    = 1'($urandom);
      exc_r   = ($urandom_range(0, 5) == 0);
      code_r  = 2'($urandom);
      for (int i = 0; i < 3; i++) rst_r[i] = ($urandom_range(0, 39) == 0);
      step();
    end
    rst_r = 3'b000;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
